// File: rtl/nes_bus_pkg.sv
// Shared definitions for the NES CPU memory bus: bus geometry, drain address
// and the bus-owner encoding reported by the arbiter.
`timescale 1ns/1ps
package nes_bus_pkg;

   localparam int          AW         = 16;
   localparam int          DW         = 8;
   localparam logic [15:0] DRAIN_ADDR = 16'h0000;

   typedef enum logic [1:0] {
      OWN_CPU   = 2'd0,
      OWN_HCI   = 2'd1,
      OWN_AUX   = 2'd2,
      OWN_DRAIN = 2'd3
   } owner_e;

endpackage

// File: rtl/cpumc_arb.sv
// Shared CPU memory bus arbiter: CPU is the default owner, HCI outranks AUX,
// and every ownership change passes through a side-effect-free drain cycle.
`timescale 1ns/1ps
module cpumc_arb #(
   parameter int            AW            = nes_bus_pkg::AW,
   parameter int            DW            = nes_bus_pkg::DW,
   parameter int            AUX_MAX_BURST = 64,
   parameter logic [AW-1:0] DRAIN_ADDR    = AW'(nes_bus_pkg::DRAIN_ADDR)
) (
   input  logic          clk_in,
   input  logic          nrst_in,
   input  logic [AW-1:0] cpu_a_in,
   input  logic [DW-1:0] cpu_d_in,
   input  logic          cpu_r_nw_in,
   output logic          cpu_rdy_out,
   input  logic          hci_req_in,
   input  logic [AW-1:0] hci_a_in,
   input  logic [DW-1:0] hci_d_in,
   input  logic          hci_r_nw_in,
   output logic          hci_gnt_out,
   output logic          hci_rvalid_out,
   input  logic          aux_req_in,
   input  logic [AW-1:0] aux_a_in,
   input  logic [DW-1:0] aux_d_in,
   input  logic          aux_r_nw_in,
   output logic          aux_gnt_out,
   output logic          aux_rvalid_out,
   output logic [AW-1:0] mem_a_out,
   output logic [DW-1:0] mem_d_out,
   output logic          mem_r_nw_out,
   input  logic [DW-1:0] mem_d_in,
   output logic [1:0]    owner_out
);
   import nes_bus_pkg::*;

   localparam logic [6:0] BURST_LIM = 7'(AUX_MAX_BURST);

   owner_e        state_q, state_d;
   owner_e        next_owner_q, next_owner_d;
   logic [6:0]    burst_q, burst_d, burst_inc_s;
   logic          cpu_owed_q, cpu_owed_d;
   logic          cpu_rdy_q, hci_gnt_q, aux_gnt_q;
   logic          hci_rvalid_q, aux_rvalid_q;
   logic [AW-1:0] mem_a_s;
   logic [DW-1:0] mem_d_s;
   logic          mem_r_nw_s;
   logic          mem_d_unused_s;

   // Read data is consumed by the requesters directly; the arbiter only flags it.
   assign mem_d_unused_s = ^mem_d_in;

   // Ownership sequencing; cpu_owed marks an AUX tenure not yet followed by a CPU cycle.
   always_comb begin
      state_d      = state_q;
      next_owner_d = next_owner_q;
      burst_d      = burst_q;
      cpu_owed_d   = cpu_owed_q;
      burst_inc_s  = (burst_q == 7'h7F) ? burst_q : burst_q + 7'd1;
      case (state_q)
         OWN_CPU: begin
            cpu_owed_d = 1'b0;
            if (hci_req_in) begin
               state_d      = OWN_DRAIN;
               next_owner_d = OWN_HCI;
            end else if (aux_req_in) begin
               state_d      = OWN_DRAIN;
               next_owner_d = OWN_AUX;
            end else begin
               state_d      = OWN_CPU;
            end
         end
         OWN_HCI: begin
            if (!hci_req_in) begin
               state_d      = OWN_DRAIN;
               next_owner_d = (aux_req_in && !cpu_owed_q) ? OWN_AUX : OWN_CPU;
            end else begin
               state_d      = OWN_HCI;
            end
         end
         OWN_AUX: begin
            burst_d = burst_inc_s;
            if (hci_req_in) begin
               state_d      = OWN_DRAIN;
               next_owner_d = OWN_HCI;
               cpu_owed_d   = 1'b1;
            end else if (!aux_req_in || (burst_inc_s >= BURST_LIM)) begin
               state_d      = OWN_DRAIN;
               next_owner_d = OWN_CPU;
               cpu_owed_d   = 1'b1;
            end else begin
               state_d      = OWN_AUX;
            end
         end
         OWN_DRAIN: begin
            next_owner_d = OWN_CPU;
            case (next_owner_q)
               OWN_HCI: state_d = OWN_HCI;
               OWN_AUX: state_d = hci_req_in ? OWN_HCI : OWN_AUX;
               OWN_CPU: state_d = OWN_CPU;
               default: state_d = OWN_CPU;
            endcase
            if (state_d == OWN_AUX) begin
               burst_d = 7'd0;
            end else begin
               burst_d = burst_q;
            end
         end
         default: begin
            state_d      = OWN_CPU;
            next_owner_d = OWN_CPU;
         end
      endcase
   end

   // Grants decode the next state so they line up with the registered owner.
   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state_q      <= OWN_CPU;
         next_owner_q <= OWN_CPU;
         burst_q      <= 7'd0;
         cpu_owed_q   <= 1'b0;
         cpu_rdy_q    <= 1'b1;
         hci_gnt_q    <= 1'b0;
         aux_gnt_q    <= 1'b0;
         hci_rvalid_q <= 1'b0;
         aux_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         next_owner_q <= next_owner_d;
         burst_q      <= burst_d;
         cpu_owed_q   <= cpu_owed_d;
         cpu_rdy_q    <= (state_d == OWN_CPU);
         hci_gnt_q    <= (state_d == OWN_HCI);
         aux_gnt_q    <= (state_d == OWN_AUX);
         hci_rvalid_q <= hci_gnt_q & hci_r_nw_in;
         aux_rvalid_q <= aux_gnt_q & aux_r_nw_in;
      end
   end

   // Bus mux on the registered owner; drain cycles issue a harmless WRAM read.
   always_comb begin
      mem_a_s    = cpu_a_in;
      mem_d_s    = cpu_d_in;
      mem_r_nw_s = cpu_r_nw_in;
      case (state_q)
         OWN_CPU: begin
            mem_a_s    = cpu_a_in;
            mem_d_s    = cpu_d_in;
            mem_r_nw_s = cpu_r_nw_in;
         end
         OWN_HCI: begin
            mem_a_s    = hci_a_in;
            mem_d_s    = hci_d_in;
            mem_r_nw_s = hci_r_nw_in;
         end
         OWN_AUX: begin
            mem_a_s    = aux_a_in;
            mem_d_s    = aux_d_in;
            mem_r_nw_s = aux_r_nw_in;
         end
         default: begin
            mem_a_s    = DRAIN_ADDR;
            mem_d_s    = {DW{1'b0}};
            mem_r_nw_s = 1'b1;
         end
      endcase
   end

   // Holding reset forces a read so no write escapes while the bus settles.
   assign mem_a_out      = mem_a_s;
   assign mem_d_out      = mem_d_s;
   assign mem_r_nw_out   = mem_r_nw_s | ~nrst_in;
   assign owner_out      = state_q;
   assign cpu_rdy_out    = cpu_rdy_q;
   assign hci_gnt_out    = hci_gnt_q;
   assign aux_gnt_out    = aux_gnt_q;
   assign hci_rvalid_out = hci_rvalid_q;
   assign aux_rvalid_out = aux_rvalid_q;

endmodule

// File: tb/tb_cpumc_arb.sv
// Scoreboard bench for cpumc_arb: a tenure-level reference model predicts the
// bus/grant picture of every cycle and the rvalid stream, a monitor compares.
`timescale 1ns/1ps
module tb_cpumc_arb;
   import nes_bus_pkg::*;

   localparam int MAXB = 64;

   logic        clk_in = 1'b0;
   logic        nrst_in;
   logic [15:0] cpu_a_in, hci_a_in, aux_a_in, mem_a_out;
   logic [7:0]  cpu_d_in, hci_d_in, aux_d_in, mem_d_out, mem_d_in;
   logic        cpu_r_nw_in, hci_r_nw_in, aux_r_nw_in, mem_r_nw_out;
   logic        hci_req_in, aux_req_in;
   logic        cpu_rdy_out, hci_gnt_out, aux_gnt_out, hci_rvalid_out, aux_rvalid_out;
   logic [1:0]  owner_out;

   cpumc_arb #(.AUX_MAX_BURST(MAXB)) dut (
      .clk_in(clk_in), .nrst_in(nrst_in),
      .cpu_a_in(cpu_a_in), .cpu_d_in(cpu_d_in), .cpu_r_nw_in(cpu_r_nw_in), .cpu_rdy_out(cpu_rdy_out),
      .hci_req_in(hci_req_in), .hci_a_in(hci_a_in), .hci_d_in(hci_d_in), .hci_r_nw_in(hci_r_nw_in),
      .hci_gnt_out(hci_gnt_out), .hci_rvalid_out(hci_rvalid_out),
      .aux_req_in(aux_req_in), .aux_a_in(aux_a_in), .aux_d_in(aux_d_in), .aux_r_nw_in(aux_r_nw_in),
      .aux_gnt_out(aux_gnt_out), .aux_rvalid_out(aux_rvalid_out),
      .mem_a_out(mem_a_out), .mem_d_out(mem_d_out), .mem_r_nw_out(mem_r_nw_out),
      .mem_d_in(mem_d_in), .owner_out(owner_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [1:0]  own;
      logic        rdy;
      logic        hg;
      logic        ag;
      logic [15:0] a;
      logic [7:0]  d;
      logic        rnw;
   } bus_t;
   typedef struct { int cyc; int who; } rv_t;

   bus_t exp_q[$];
   rv_t  rv_q[$];
   int   aux_runs[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // reference model: owner 0=CPU 1=HCI 2=AUX 3=drain, plus tenure bookkeeping
   int m_owner, m_target, m_aux_run, m_last_cpu, m_last_aux_end;

   logic [15:0] nx_cpu_a, nx_hci_a, nx_aux_a;
   logic [7:0]  nx_cpu_d, nx_hci_d, nx_aux_d;
   logic        nx_cpu_rnw, nx_hci_rnw, nx_aux_rnw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_reset();
      m_owner       = 0;
      m_target      = 0;
      m_aux_run     = 0;
      m_last_cpu    = -1;
      m_last_aux_end = -2;
   endtask

   task automatic rand_bus();
      nx_cpu_a = 16'($urandom);  nx_cpu_d = 8'($urandom);  nx_cpu_rnw = 1'($urandom_range(0, 1));
      nx_hci_a = 16'($urandom);  nx_hci_d = 8'($urandom);  nx_hci_rnw = 1'($urandom_range(0, 1));
      nx_aux_a = 16'($urandom);  nx_aux_d = 8'($urandom);  nx_aux_rnw = 1'($urandom_range(0, 1));
   endtask

   // Advance the model over the clock edge that closes cycle 'cyc'.
   task automatic model_edge();
      bit h;
      bit a;
      h = hci_req_in;
      a = aux_req_in;
      if (m_owner == 1 && hci_r_nw_in) rv_q.push_back('{cyc + 1, 1});
      if (m_owner == 2 && aux_r_nw_in) rv_q.push_back('{cyc + 1, 2});
      case (m_owner)
         0: begin
            m_last_cpu = cyc;
            if (h) begin m_target = 1; m_owner = 3; end
            else if (a) begin m_target = 2; m_owner = 3; end
         end
         1: if (!h) begin
            m_target = (a && m_last_cpu > m_last_aux_end) ? 2 : 0;
            m_owner  = 3;
         end
         2: begin
            m_aux_run++;
            if (h || !a || m_aux_run >= MAXB) begin
               m_target       = h ? 1 : 0;
               m_owner        = 3;
               m_last_aux_end = cyc;
            end
         end
         default: begin
            m_owner   = (m_target == 2 && h) ? 1 : m_target;
            m_aux_run = 0;
         end
      endcase
   endtask

   task automatic push_expect();
      bus_t e;
      e.own = 2'(m_owner);
      e.rdy = (m_owner == 0);
      e.hg  = (m_owner == 1);
      e.ag  = (m_owner == 2);
      case (m_owner)
         0:       begin e.a = cpu_a_in; e.d = cpu_d_in; e.rnw = cpu_r_nw_in; end
         1:       begin e.a = hci_a_in; e.d = hci_d_in; e.rnw = hci_r_nw_in; end
         2:       begin e.a = aux_a_in; e.d = aux_d_in; e.rnw = aux_r_nw_in; end
         default: begin e.a = 16'h0000; e.d = 8'h00;   e.rnw = 1'b1;        end
      endcase
      exp_q.push_back(e);
   endtask

   task automatic drive_cycle(input bit h, input bit a);
      @(posedge clk_in);
      model_edge();
      cyc++;
      #1;
      hci_req_in = h;           aux_req_in = a;
      cpu_a_in = nx_cpu_a;      cpu_d_in = nx_cpu_d;      cpu_r_nw_in = nx_cpu_rnw;
      hci_a_in = nx_hci_a;      hci_d_in = nx_hci_d;      hci_r_nw_in = nx_hci_rnw;
      aux_a_in = nx_aux_a;      aux_d_in = nx_aux_d;      aux_r_nw_in = nx_aux_rnw;
      mem_d_in = 8'($urandom);
      push_expect();
      rand_bus();
   endtask

   task automatic chk_rv(input int who);
      tests++;
      if (rv_q.size() > 0 && rv_q[0].cyc == cyc && rv_q[0].who == who) begin
         void'(rv_q.pop_front());
      end else begin
         fails++;
         $display("FAIL rvalid_unexpected: requester %0d got rvalid=1 expected 0 (cycle %0d)", who, cyc);
      end
   endtask

   bus_t mon_e, mon_act;
   int   run_len = 0;

   // Monitor: compares each predicted cycle and matches rvalid pulses.
   always @(negedge clk_in) begin
      if (nrst_in) begin
         mon_act = {owner_out, cpu_rdy_out, hci_gnt_out, aux_gnt_out, mem_a_out, mem_d_out, mem_r_nw_out};
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("bus_cycle", 32'(mon_act), 32'(mon_e));
         end
         if (hci_rvalid_out) chk_rv(1);
         if (aux_rvalid_out) chk_rv(2);
         while (rv_q.size() > 0 && rv_q[0].cyc <= cyc) begin
            tests++;
            fails++;
            $display("FAIL rvalid_missing: requester %0d got rvalid=0 expected 1 (cycle %0d)", rv_q[0].who, rv_q[0].cyc);
            void'(rv_q.pop_front());
         end
      end
   end

   // Records the length of every AUX grant run.
   always @(negedge clk_in) begin
      if (!nrst_in) run_len = 0;
      else if (aux_gnt_out) run_len++;
      else if (run_len != 0) begin aux_runs.push_back(run_len); run_len = 0; end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit h, a;
      nrst_in = 1'b0;
      hci_req_in = 1'b0; aux_req_in = 1'b0;
      cpu_a_in = 16'h1234; cpu_d_in = 8'h55; cpu_r_nw_in = 1'b0;
      hci_a_in = 16'h0; hci_d_in = 8'h0; hci_r_nw_in = 1'b0;
      aux_a_in = 16'h0; aux_d_in = 8'h0; aux_r_nw_in = 1'b0;
      mem_d_in = 8'h00;
      model_reset();
      rand_bus();
      #12;
      check("rst_owner", owner_out, 2'd0);
      check("rst_cpu_rdy", cpu_rdy_out, 1'b1);
      check("rst_hci_gnt", hci_gnt_out, 1'b0);
      check("rst_aux_gnt", aux_gnt_out, 1'b0);
      check("rst_rvalids", {hci_rvalid_out, aux_rvalid_out}, 2'b00);
      check("rst_no_write", mem_r_nw_out, 1'b1);
      @(negedge clk_in);
      #1 nrst_in = 1'b1;

      // CPU write passes straight through
      nx_cpu_a = 16'h0010; nx_cpu_d = 8'hA5; nx_cpu_rnw = 1'b0;
      drive_cycle(1'b0, 1'b0);
      @(negedge clk_in);
      check("cpu_pass_a", mem_a_out, 16'h0010);
      check("cpu_pass_d", mem_d_out, 8'hA5);
      check("cpu_pass_rnw", mem_r_nw_out, 1'b0);
      check("cpu_pass_owner", owner_out, 2'd0);

      // HCI grant latency and single read
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0);
      @(negedge clk_in);
      check("hci_drain_owner", owner_out, 2'd3);
      check("hci_drain_a", mem_a_out, 16'h0000);
      check("hci_drain_rnw", mem_r_nw_out, 1'b1);
      nx_hci_a = 16'h2002; nx_hci_rnw = 1'b1;
      drive_cycle(1'b1, 1'b0);
      @(negedge clk_in);
      check("hci_gnt", hci_gnt_out, 1'b1);
      check("hci_cpu_stalled", cpu_rdy_out, 1'b0);
      check("hci_read_a", mem_a_out, 16'h2002);
      drive_cycle(1'b1, 1'b0);
      @(negedge clk_in);
      check("hci_rvalid", hci_rvalid_out, 1'b1);
      repeat (4) drive_cycle(1'b0, 1'b0);

      // AUX held: bursts capped, CPU slot between them
      aux_runs.delete();
      repeat (200) drive_cycle(1'b0, 1'b1);
      repeat (4) drive_cycle(1'b0, 1'b0);
      check("aux_run_count_ge2", (aux_runs.size() >= 2), 1'b1);
      if (aux_runs.size() >= 2) begin
         check("aux_burst_first", aux_runs[0], MAXB);
         check("aux_burst_second", aux_runs[1], MAXB);
      end

      // HCI preempts AUX; in-flight AUX read still completes
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b0, 1'b1);
         @(negedge clk_in);
         if (aux_gnt_out) break;
      end
      check("preempt_setup_aux_gnt", aux_gnt_out, 1'b1);
      nx_aux_rnw = 1'b1;
      drive_cycle(1'b1, 1'b1);
      @(negedge clk_in);
      check("preempt_aux_still", aux_gnt_out, 1'b1);
      drive_cycle(1'b1, 1'b1);
      @(negedge clk_in);
      check("preempt_aux_drop", aux_gnt_out, 1'b0);
      check("preempt_aux_rvalid", aux_rvalid_out, 1'b1);
      drive_cycle(1'b1, 1'b1);
      @(negedge clk_in);
      check("preempt_hci_gnt", hci_gnt_out, 1'b1);
      drive_cycle(1'b0, 1'b1);
      repeat (8) drive_cycle(1'b0, 1'b0);

      // Simultaneous requests: HCI first, then drain straight to AUX
      drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b1, 1'b1);
      @(negedge clk_in);
      check("simul_hci_first", {hci_gnt_out, aux_gnt_out}, 2'b10);
      drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1);
      @(negedge clk_in);
      check("simul_drain", owner_out, 2'd3);
      drive_cycle(1'b0, 1'b1);
      @(negedge clk_in);
      check("simul_aux_after_hci", aux_gnt_out, 1'b1);
      repeat (4) drive_cycle(1'b0, 1'b0);

      // Randomised level-held requests
      h = 1'b0;
      a = 1'b0;
      repeat (2000) begin
         if ($urandom_range(0, 11) == 0) h = ~h;
         if ($urandom_range(0, 7) == 0)  a = ~a;
         drive_cycle(h, a);
      end
      repeat (4) drive_cycle(1'b0, 1'b0);

      // Reset in the middle of an HCI write burst
      for (int i = 0; i < 8; i++) begin
         nx_hci_rnw = 1'b0;
         drive_cycle(1'b1, 1'b0);
         @(negedge clk_in);
         if (hci_gnt_out) break;
      end
      check("rst_setup_hci_gnt", hci_gnt_out, 1'b1);
      nx_hci_rnw = 1'b0; nx_cpu_rnw = 1'b0;
      drive_cycle(1'b1, 1'b1);
      #2 nrst_in = 1'b0;
      #1;
      check("midrst_hci_gnt", hci_gnt_out, 1'b0);
      check("midrst_aux_gnt", aux_gnt_out, 1'b0);
      check("midrst_cpu_rdy", cpu_rdy_out, 1'b1);
      check("midrst_no_write", mem_r_nw_out, 1'b1);
      check("midrst_owner", owner_out, 2'd0);
      exp_q.delete();
      rv_q.delete();
      hci_req_in = 1'b0; aux_req_in = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      #1 nrst_in = 1'b1;
      model_reset();
      check("postrst_owner", owner_out, 2'd0);
      repeat (20) drive_cycle(1'b0, 1'b0);
      @(negedge clk_in);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
